// File: rtl/fwd_hazard_tracker_if.sv
// Decode-to-tracker bundle.
// master : decode side. It drives the instruction fields, hold and flush,
//          and reads fwd_sel, stall and stall_cnt.
// slave  : the hazard tracker, which receives the fields and drives the results.
interface fwd_hazard_tracker_if #(
  parameter int unsigned REG_ADDR_W = 3,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned FWD_DEPTH  = 2,
  parameter int unsigned CNT_W      = 16
);
  localparam int unsigned SEL_W = $clog2(FWD_DEPTH + 1);

  logic                          id_valid;
  logic [NUM_SRC*REG_ADDR_W-1:0] id_src_addr;
  logic [NUM_SRC-1:0]            id_src_used;
  logic [REG_ADDR_W-1:0]         id_dst_addr;
  logic                          id_dst_wen;
  logic                          id_is_load;
  logic                          hold;
  logic                          flush;
  logic [NUM_SRC*SEL_W-1:0]      fwd_sel;
  logic                          stall;
  logic [CNT_W-1:0]              stall_cnt;

  modport master (
    output id_valid, id_src_addr, id_src_used, id_dst_addr, id_dst_wen,
           id_is_load, hold, flush,
    input  fwd_sel, stall, stall_cnt
  );

  modport slave (
    input  id_valid, id_src_addr, id_src_used, id_dst_addr, id_dst_wen,
           id_is_load, hold, flush,
    output fwd_sel, stall, stall_cnt
  );
endinterface

// File: rtl/fwd_hazard_tracker.sv
// Operand-forwarding and load-use hazard tracker for the decode stage.
// The tracker keeps its own record of in-flight destination registers. It
// drives a per-operand forwarding select and a load-use stall, and it keeps a
// saturating count of stall cycles.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous reset, active-high
//   bus  : fwd_hazard_tracker_if.slave (decode fields in; fwd_sel, stall and stall_cnt out)
// fwd_sel and stall are combinational from the tracked entries and the current
// decode fields, so the operand muxes see them in the same cycle.
module fwd_hazard_tracker #(
  parameter int unsigned REG_ADDR_W = 3,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned FWD_DEPTH  = 2,
  parameter int unsigned CNT_W      = 16
) (
  input logic                 clk,
  input logic                 rst,
  fwd_hazard_tracker_if.slave bus
);
  localparam int unsigned SEL_W = $clog2(FWD_DEPTH + 1);

  // Entry k describes the instruction that is k stages past decode.
  logic [FWD_DEPTH:1]    vld_q;
  logic                  wen_q  [1:FWD_DEPTH];
  logic                  ld_q   [1:FWD_DEPTH];
  logic [REG_ADDR_W-1:0] addr_q [1:FWD_DEPTH];
  logic [CNT_W-1:0]      cnt_q;

  logic [NUM_SRC*SEL_W-1:0] sel_c;
  logic                     hit_ld_c;
  logic                     hz_c;

  // Scan from the oldest entry to the youngest so that the youngest match overwrites older ones.
  always_comb begin
    sel_c    = '0;
    hit_ld_c = 1'b0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      for (int k = int'(FWD_DEPTH); k >= 1; k--) begin
        if (bus.id_src_used[i] && vld_q[k] && wen_q[k] &&
            (addr_q[k] == bus.id_src_addr[i*REG_ADDR_W +: REG_ADDR_W])) begin
          sel_c[i*SEL_W +: SEL_W] = SEL_W'(int'(FWD_DEPTH) + 1 - k);
          if ((k == 1) && ld_q[1]) begin
            hit_ld_c = 1'b1;
          end
        end
      end
    end
    hz_c = bus.id_valid && !bus.flush && hit_ld_c;
  end

  assign bus.fwd_sel   = sel_c;
  assign bus.stall     = hz_c;
  assign bus.stall_cnt = cnt_q;

  // Advance the entries. A stall or a flush puts a bubble into entry 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      cnt_q <= '0;
    end else if (!bus.hold) begin
      for (int k = int'(FWD_DEPTH); k >= 2; k--) begin
        vld_q[k]  <= vld_q[k-1];
        wen_q[k]  <= wen_q[k-1];
        ld_q[k]   <= ld_q[k-1];
        addr_q[k] <= addr_q[k-1];
      end
      vld_q[1]  <= bus.id_valid && !bus.flush && !hz_c;
      wen_q[1]  <= bus.id_dst_wen;
      ld_q[1]   <= bus.id_is_load;
      addr_q[1] <= bus.id_dst_addr;
      if (hz_c && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_fwd_hazard_tracker.sv
// Directed bench for fwd_hazard_tracker. Instance dut uses the default
// parameters. Instance dutp uses FWD_DEPTH=3 and CNT_W=2, for the saturation
// and depth checks.
module tb_fwd_hazard_tracker;
  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  fwd_hazard_tracker_if #(.REG_ADDR_W(3), .NUM_SRC(2), .FWD_DEPTH(2), .CNT_W(16)) bus ();
  fwd_hazard_tracker_if #(.REG_ADDR_W(3), .NUM_SRC(2), .FWD_DEPTH(3), .CNT_W(2))  busp ();

  fwd_hazard_tracker #(.REG_ADDR_W(3), .NUM_SRC(2), .FWD_DEPTH(2), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  fwd_hazard_tracker #(.REG_ADDR_W(3), .NUM_SRC(2), .FWD_DEPTH(3), .CNT_W(2)) dutp (
    .clk (clk),
    .rst (rst),
    .bus (busp.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock. Inputs change 1 time unit after the edge, and checks happen 1 unit later still.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [2:0] s0, input logic [2:0] s1,
                     input logic [1:0] used, input logic [2:0] dst, input logic wen,
                     input logic ld);
    bus.id_valid    = v;
    bus.id_src_addr = {s1, s0};
    bus.id_src_used = used;
    bus.id_dst_addr = dst;
    bus.id_dst_wen  = wen;
    bus.id_is_load  = ld;
    #1;
  endtask

  task automatic drvp(input logic v, input logic [2:0] s0, input logic [1:0] used,
                      input logic [2:0] dst, input logic wen, input logic ld);
    busp.id_valid    = v;
    busp.id_src_addr = {3'd0, s0};
    busp.id_src_used = used;
    busp.id_dst_addr = dst;
    busp.id_dst_wen  = wen;
    busp.id_is_load  = ld;
    #1;
  endtask

  task automatic drain();
    drv(1'b0, 3'd0, 3'd0, 2'b00, 3'd0, 1'b0, 1'b0);
    drvp(1'b0, 3'd0, 2'b00, 3'd0, 1'b0, 1'b0);
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.hold = 1'b0;  bus.flush = 1'b0;
    busp.hold = 1'b0; busp.flush = 1'b0;
    drv(1'b1, 3'd3, 3'd3, 2'b11, 3'd3, 1'b1, 1'b1);
    drvp(1'b1, 3'd3, 2'b11, 3'd3, 1'b1, 1'b1);
    tick();
    tick();
    rst = 1'b0;
    #1;
    n_vec++;
    if (bus.fwd_sel !== 4'b0000) begin
      n_err++; $display("FAIL reset_fwd_sel got %b want 0000", bus.fwd_sel);
    end
    n_vec++;
    if (bus.stall !== 1'b0) begin
      n_err++; $display("FAIL reset_stall got %b want 0", bus.stall);
    end
    n_vec++;
    if (bus.stall_cnt !== 16'd0) begin
      n_err++; $display("FAIL reset_stall_cnt got %0d want 0", bus.stall_cnt);
    end
    n_vec++;
    if ({busp.fwd_sel, busp.stall, busp.stall_cnt} !== 7'b0) begin
      n_err++; $display("FAIL reset_p got %b want 0000000", {busp.fwd_sel, busp.stall, busp.stall_cnt});
    end
    drain();
  endtask

  task automatic test_alu_chain();
    drv(1'b1, 3'd0, 3'd0, 2'b00, 3'd2, 1'b1, 1'b0);  // I1 writes R2
    tick();
    drv(1'b1, 3'd2, 3'd0, 2'b01, 3'd6, 1'b0, 1'b0);  // I2 reads R2
    n_vec++;
    if (bus.fwd_sel !== 4'b0010) begin
      n_err++; $display("FAIL alu_exmem got %b want 0010", bus.fwd_sel);
    end
    tick();
    drv(1'b1, 3'd0, 3'd2, 2'b10, 3'd6, 1'b0, 1'b0);  // I3 reads R2 on operand 1
    n_vec++;
    if (bus.fwd_sel !== 4'b0100) begin
      n_err++; $display("FAIL alu_memwb got %b want 0100", bus.fwd_sel);
    end
    tick();
    drv(1'b1, 3'd2, 3'd2, 2'b11, 3'd6, 1'b0, 1'b0);
    n_vec++;
    if (bus.fwd_sel !== 4'b0000) begin
      n_err++; $display("FAIL alu_regfile got %b want 0000", bus.fwd_sel);
    end
    drain();
  endtask

  task automatic test_priority();
    drv(1'b1, 3'd0, 3'd0, 2'b00, 3'd5, 1'b1, 1'b0);
    tick();
    drv(1'b1, 3'd0, 3'd0, 2'b00, 3'd5, 1'b1, 1'b0);
    tick();
    drv(1'b1, 3'd5, 3'd5, 2'b11, 3'd0, 1'b0, 1'b0);
    n_vec++;
    if (bus.fwd_sel !== 4'b1010) begin
      n_err++; $display("FAIL priority got %b want 1010", bus.fwd_sel);
    end
    drain();
  endtask

  task automatic test_load_use();
    drv(1'b1, 3'd0, 3'd0, 2'b00, 3'd4, 1'b1, 1'b1);  // load R4
    tick();
    drv(1'b1, 3'd4, 3'd0, 2'b01, 3'd1, 1'b1, 1'b0);  // dependent, writes R1
    n_vec++;
    if (bus.stall !== 1'b1) begin
      n_err++; $display("FAIL load_use_stall got %b want 1", bus.stall);
    end
    tick();
    n_vec++;
    if ({bus.stall, bus.fwd_sel} !== 5'b0_0001) begin
      n_err++; $display("FAIL load_use_replay got %b want 00001", {bus.stall, bus.fwd_sel});
    end
    n_vec++;
    if (bus.stall_cnt !== 16'd1) begin
      n_err++; $display("FAIL load_use_cnt got %0d want 1", bus.stall_cnt);
    end
    tick();
    drv(1'b1, 3'd1, 3'd0, 2'b01, 3'd0, 1'b0, 1'b0);  // reads R1 from the replayed instruction
    n_vec++;
    if ({bus.stall, bus.fwd_sel} !== 5'b0_0010) begin
      n_err++; $display("FAIL load_use_advance got %b want 00010", {bus.stall, bus.fwd_sel});
    end
    drain();
  endtask

  task automatic test_flush_hold_unused();
    // A flush suppresses the stall, and the bubble it creates is not counted.
    drv(1'b1, 3'd0, 3'd0, 2'b00, 3'd4, 1'b1, 1'b1);
    tick();
    bus.flush = 1'b1;
    drv(1'b1, 3'd4, 3'd0, 2'b01, 3'd0, 1'b0, 1'b0);
    n_vec++;
    if (bus.stall !== 1'b0) begin
      n_err++; $display("FAIL flush_stall got %b want 0", bus.stall);
    end
    tick();
    bus.flush = 1'b0;
    #1;
    n_vec++;
    if ({bus.stall, bus.fwd_sel, bus.stall_cnt} !== {1'b0, 4'b0001, 16'd1}) begin
      n_err++; $display("FAIL flush_after got stall=%b sel=%b cnt=%0d want 0 0001 1",
                        bus.stall, bus.fwd_sel, bus.stall_cnt);
    end
    drain();
    // Hold freezes the entries and the counter while a load-use match is pending.
    drv(1'b1, 3'd0, 3'd0, 2'b00, 3'd3, 1'b1, 1'b1);
    tick();
    bus.hold = 1'b1;
    drv(1'b1, 3'd3, 3'd0, 2'b01, 3'd0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      n_vec++;
      if ({bus.stall, bus.fwd_sel, bus.stall_cnt} !== {1'b1, 4'b0010, 16'd1}) begin
        n_err++; $display("FAIL hold_cycle%0d got stall=%b sel=%b cnt=%0d want 1 0010 1",
                          c, bus.stall, bus.fwd_sel, bus.stall_cnt);
      end
      tick();
    end
    bus.hold = 1'b0;
    #1;
    tick();
    n_vec++;
    if ({bus.stall, bus.fwd_sel, bus.stall_cnt} !== {1'b0, 4'b0001, 16'd2}) begin
      n_err++; $display("FAIL hold_release got stall=%b sel=%b cnt=%0d want 0 0001 2",
                        bus.stall, bus.fwd_sel, bus.stall_cnt);
    end
    drain();
    // An operand that is not read never matches.
    drv(1'b1, 3'd0, 3'd0, 2'b00, 3'd6, 1'b1, 1'b0);
    tick();
    drv(1'b1, 3'd6, 3'd6, 2'b10, 3'd0, 1'b0, 1'b0);
    n_vec++;
    if (bus.fwd_sel !== 4'b1000) begin
      n_err++; $display("FAIL unused_operand got %b want 1000", bus.fwd_sel);
    end
    drain();
  endtask

  task automatic test_saturation();
    for (int n = 1; n <= 5; n++) begin
      drvp(1'b1, 3'd0, 2'b00, 3'd7, 1'b1, 1'b1);
      tick();
      drvp(1'b1, 3'd7, 2'b01, 3'd0, 1'b0, 1'b0);
      n_vec++;
      if (busp.stall !== 1'b1) begin
        n_err++; $display("FAIL sat_stall%0d got %b want 1", n, busp.stall);
      end
      tick();
      n_vec++;
      if (busp.stall_cnt !== 2'((n > 3) ? 3 : n)) begin
        n_err++; $display("FAIL sat_cnt%0d got %0d want %0d", n, busp.stall_cnt, (n > 3) ? 3 : n);
      end
    end
    drain();
  endtask

  task automatic test_depth3();
    drvp(1'b1, 3'd0, 2'b00, 3'd1, 1'b1, 1'b0);
    tick();
    drvp(1'b1, 3'd0, 2'b00, 3'd2, 1'b1, 1'b0);
    tick();
    drvp(1'b1, 3'd0, 2'b00, 3'd3, 1'b1, 1'b0);
    tick();
    drvp(1'b1, 3'd1, 2'b01, 3'd0, 1'b0, 1'b0);
    n_vec++;
    if (busp.fwd_sel !== 4'b0001) begin
      n_err++; $display("FAIL depth3_entry3 got %b want 0001", busp.fwd_sel);
    end
    drvp(1'b1, 3'd2, 2'b01, 3'd0, 1'b0, 1'b0);
    n_vec++;
    if (busp.fwd_sel !== 4'b0010) begin
      n_err++; $display("FAIL depth3_entry2 got %b want 0010", busp.fwd_sel);
    end
    drvp(1'b1, 3'd3, 2'b01, 3'd0, 1'b0, 1'b0);
    n_vec++;
    if (busp.fwd_sel !== 4'b0011) begin
      n_err++; $display("FAIL depth3_entry1 got %b want 0011", busp.fwd_sel);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    // Self-reference does not match. A write one cycle later still wins over the older entry.
    drv(1'b1, 3'd0, 3'd0, 2'b01, 3'd0, 1'b1, 1'b0);   // writes R0 while reading R0
    n_vec++;
    if (bus.fwd_sel !== 4'b0000) begin
      n_err++; $display("FAIL self_ref got %b want 0000", bus.fwd_sel);
    end
    tick();
    drv(1'b1, 3'd0, 3'd0, 2'b01, 3'd0, 1'b1, 1'b0);   // R0 is an ordinary register
    n_vec++;
    if (bus.fwd_sel !== 4'b0010) begin
      n_err++; $display("FAIL r0_forward got %b want 0010", bus.fwd_sel);
    end
    tick();
    drv(1'b1, 3'd0, 3'd0, 2'b11, 3'd0, 1'b0, 1'b0);
    n_vec++;
    if (bus.fwd_sel !== 4'b1010) begin
      n_err++; $display("FAIL b2b_youngest got %b want 1010", bus.fwd_sel);
    end
    drain();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_alu_chain();
    test_priority();
    test_load_use();
    test_flush_hold_unused();
    test_saturation();
    test_depth3();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
